l0_pool_reader: RTL and testbench
=================================

L0_POOL_READER -- requirements
Module: l0_pool_reader

Interface
REQ-001 Parameter DW, 18, signed sample width of the layer-0 feature-map RAM.
REQ-002 Parameter MAP_W, 26, feature-map width and height in samples (MAP_W*MAP_W = 676 words).
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle pulse; begins a full pooling sweep; ignored unless the block is IDLE.
REQ-006 addr_rd  output  10  read address to the feature-map RAM.
REQ-007 ram_dout  input  DW  RAM read data; valid exactly one cycle after addr_rd is presented.
REQ-008 out_valid  output  1  pooled sample available.
REQ-009 out_ready  input  1  downstream accepts the sample; transfer occurs when out_valid and out_ready are both high.
REQ-010 out_data  output  DW  pooled sample, two's complement.
REQ-011 out_idx  output  8  pooled-map index 0..168, row-major over a 13x13 grid.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when a sweep completes.

Function
REQ-014 Sweep: 2x2, stride-2 max-pool over the 26x26 map; 169 windows in row-major order (pr 0..12 outer, pc 0..12 inner).
REQ-015 Window base address b = (2*pr)*MAP_W + 2*pc; the four reads are issued in order b, b+1, b+MAP_W, b+MAP_W+1; address arithmetic 10 bits wide, maximum address 675, never wraps.
REQ-016 FSM states: IDLE, READ, DRAIN, OUT, FIN.
REQ-017 IDLE -> READ on start; pr, pc, and the read counter k are cleared on entry.
REQ-018 READ: lasts 4 cycles; addr_rd presents read k (k = 0..3) in cycle k; data for read k is captured in cycle k+1.
REQ-019 READ -> DRAIN after k = 3; DRAIN lasts 1 cycle and captures the fourth sample.
REQ-020 Running max: the first sample loads the accumulator; subsequent samples replace it only if strictly greater (signed compare over the full DW bits).
REQ-021 DRAIN -> OUT; out_valid rises on the 6th cycle after READ is entered (latency 5 cycles from the first address); out_data/out_idx are stable while out_valid is high and out_ready is low.
REQ-022 OUT: on transfer, if out_idx = 168 -> FIN, else advance pc (wrap to 0 at 13 and increment pr) -> READ in the next cycle; minimum throughput is 1 window per 6 cycles.
REQ-023 FIN: done = 1 for exactly one cycle, busy = 1, then -> IDLE.
REQ-024 addr_rd holds its last value outside READ; out_valid = 0 in every state except OUT.
REQ-025 A start pulse arriving in any state other than IDLE (including the FIN cycle) has no effect.
REQ-026 out_ready held low indefinitely stalls in OUT with no further RAM reads.

Reset
REQ-027 rst_n = 0 at a clock edge forces IDLE from any state, including mid-window or mid-stall; the partial sweep is discarded.
REQ-028 Reset values: addr_rd = 0, out_valid = 0, out_data = 0, out_idx = 0, busy = 0, done = 0, all counters and the accumulator = 0.
REQ-029 start sampled in the same cycle that rst_n = 0 is ignored.

Configuration
REQ-030 Macro L0_POOL_RELU_EN: when defined, out_data = 0 whenever the window max is negative (ReLU fused after pooling); when undefined, the signed max is output unchanged; timing is identical in both builds.

Verification
REQ-031 RAM word i = i, start, out_ready = 1 -> 169 outputs; out_idx 0 has data 27, out_idx 168 has data 675; done pulses once; addr sequence for window 0 = 0, 1, 26, 27.
REQ-032 Window 0 words = -5, 7, 7, -100 (all other words 0) -> out_data 7 at idx 0; a window of all -3 gives -3 without the macro, 0 with L0_POOL_RELU_EN.
REQ-033 out_ready low for 10 cycles during idx 4 -> out_valid held, data/idx stable, addr_rd unchanged; resumes with idx 5 after ready.
REQ-034 rst_n asserted during READ of window 50 -> next cycle busy = 0, out_valid = 0; a new start restarts at idx 0 with addr 0.
REQ-035 start pulsed during READ and during FIN -> no restart; exactly 169 transfers and one done pulse.
REQ-036 Cycle check with out_ready = 1: first out_valid exactly 5 cycles after the first addr_rd; full sweep completes in 169*6 cycles plus FIN.

Source files
------------

// File: rtl/l0_pool_reader.sv
// Layer-0 2x2/stride-2 max-pool reader: sweeps the 26x26 feature-map RAM and streams 13x13 pooled samples.
// Optional build macro L0_POOL_RELU_EN clamps negative window maxima to zero.
module l0_pool_reader #(
    parameter int DW    = 18,
    parameter int MAP_W = 26
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [9:0]           addr_rd,
    input  logic signed [DW-1:0] ram_dout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic [7:0]           out_idx,
    output logic                 busy,
    output logic                 done
);

    // state | meaning
    // IDLE  | waiting for start
    // READ  | four window reads, k = 0..3
    // DRAIN | capture the fourth sample
    // OUT   | pooled sample offered downstream
    // FIN   | one-cycle done pulse
    typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_OUT, S_FIN} state_t;

    localparam int POOL_W = MAP_W / 2;
    localparam int LAST   = POOL_W * POOL_W - 1;

    state_t               state, state_nxt;
    logic [1:0]           k;
    logic [3:0]           pr, pc;
    logic [9:0]           base, base_nxt;
    logic signed [DW-1:0] acc, sample_max, pooled;
    logic                 xfer, last_col;

    always_comb begin
        state_nxt  = state;
        out_valid  = (state == S_OUT);
        busy       = (state != S_IDLE);
        done       = (state == S_FIN);
        xfer       = out_valid && out_ready;
        last_col   = (pc == 4'(POOL_W - 1));
        // the next window starts two rows down once the column wraps
        base_nxt   = last_col ? base + 10'(MAP_W + 2) : base + 10'd2;
        sample_max = (ram_dout > acc) ? ram_dout : acc;
`ifdef L0_POOL_RELU_EN
        pooled     = sample_max[DW-1] ? '0 : sample_max;
`else
        pooled     = sample_max;
`endif
        case (state)
            S_IDLE:  if (start) state_nxt = S_READ;
            S_READ:  if (k == 2'd3) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_OUT;
            S_OUT:   if (xfer) state_nxt = (out_idx == 8'(LAST)) ? S_FIN : S_READ;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            k        <= '0;
            pr       <= '0;
            pc       <= '0;
            base     <= '0;
            acc      <= '0;
            addr_rd  <= '0;
            out_data <= '0;
            out_idx  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k       <= '0;
                        pr      <= '0;
                        pc      <= '0;
                        base    <= '0;
                        addr_rd <= '0;
                        out_idx <= '0;
                    end
                end
                S_READ: begin
                    k <= k + 2'd1;
                    case (k)
                        2'd0:    addr_rd <= base + 10'd1;
                        2'd1:    addr_rd <= base + 10'(MAP_W);
                        2'd2:    addr_rd <= base + 10'(MAP_W + 1);
                        default: addr_rd <= addr_rd;
                    endcase
                    // data lags the address by one cycle; first sample seeds the max
                    if (k == 2'd1)
                        acc <= ram_dout;
                    else if (k != 2'd0)
                        acc <= sample_max;
                end
                S_DRAIN: begin
                    acc      <= sample_max;
                    out_data <= pooled;
                end
                S_OUT: begin
                    if (xfer && (out_idx != 8'(LAST))) begin
                        k       <= '0;
                        base    <= base_nxt;
                        addr_rd <= base_nxt;
                        out_idx <= out_idx + 8'd1;
                        if (last_col) begin
                            pc <= '0;
                            pr <= pr + 4'd1;
                        end else begin
                            pc <= pc + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_l0_pool_reader.sv
// Self-checking bench for l0_pool_reader: window table, timing sequences, stall/reset corners, random sweeps.
module tb_l0_pool_reader;
    localparam int DW    = 18;
    localparam int MAP_W = 26;
    localparam int NW    = 169;
    localparam int BUDGET = 6000;

    logic                 clk = 1'b0;
    logic                 rst_n, start, out_ready;
    logic [9:0]           addr_rd;
    logic signed [DW-1:0] ram_dout = '0;
    logic                 out_valid, busy, done;
    logic signed [DW-1:0] out_data;
    logic [7:0]           out_idx;

    l0_pool_reader #(.DW(DW), .MAP_W(MAP_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .addr_rd(addr_rd), .ram_dout(ram_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic signed [DW-1:0] mem [0:MAP_W*MAP_W-1];
    always @(posedge clk) ram_dout <= mem[addr_rd];

    int checks = 0;
    int errors = 0;
    int exp_arr [NW];
    int cap [NW];
    int addr_log [4];
    int first_valid, done_cyc, n_xfer, n_done;

    typedef struct { int v0; int v1; int v2; int v3; int exp; } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int relu(input int v);
`ifdef L0_POOL_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic build_model();
        for (int w = 0; w < NW; w++) begin
            int b, m, s;
            b = 2 * (w / 13) * MAP_W + 2 * (w % 13);
            m = mem[b];
            s = mem[b + 1];          if (s > m) m = s;
            s = mem[b + MAP_W];      if (s > m) m = s;
            s = mem[b + MAP_W + 1];  if (s > m) m = s;
            exp_arr[w] = relu(m);
        end
    endtask

    task automatic put_window(input int w, input int a, input int b, input int c, input int d);
        int base;
        base = 2 * (w / 13) * MAP_W + 2 * (w % 13);
        mem[base]             = DW'(a);
        mem[base + 1]         = DW'(b);
        mem[base + MAP_W]     = DW'(c);
        mem[base + MAP_W + 1] = DW'(d);
    endtask

    task automatic run_sweep(input int ready_pct, input bit spur_start, input int stall_idx);
        int stall_cnt, hold_data, hold_addr;
        bit ended;
        build_model();
        n_xfer = 0; n_done = 0; first_valid = -1; done_cyc = -1;
        stall_cnt = 0; hold_data = 0; hold_addr = 0; ended = 0;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= BUDGET; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (spur_start && cyc == 2) start = 1'b1;
            if (cyc <= 4) addr_log[cyc-1] = int'(addr_rd);
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
                if (spur_start) start = 1'b1;
            end
            if (out_valid && stall_idx >= 0 && int'(out_idx) == stall_idx && stall_cnt < 10) begin
                if (stall_cnt == 0) begin
                    hold_data = int'(out_data);
                    hold_addr = int'(addr_rd);
                end else begin
                    chk("stall_data", int'(out_data), hold_data);
                    chk("stall_addr", int'(addr_rd), hold_addr);
                    chk("stall_idx", int'(out_idx), stall_idx);
                end
                stall_cnt++;
                out_ready = 1'b0;
            end else begin
                out_ready = ($urandom_range(0, 99) < ready_pct);
            end
            if (out_valid && out_ready) begin
                if (n_xfer < NW) begin
                    chk("xfer_idx", int'(out_idx), n_xfer);
                    chk("xfer_data", int'(out_data), exp_arr[n_xfer]);
                    cap[n_xfer] = int'(out_data);
                end
                n_xfer++;
            end
            if (n_done > 0 && !busy) begin
                ended = 1;
                break;
            end
        end
        start = 1'b0;
        chk("sweep_ended", int'(ended), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) n_done++;
            if (i == 2) chk("idle_after_sweep", int'(busy), 0);
        end
        chk("xfer_count", n_xfer, NW);
        chk("done_count", n_done, 1);
        if (stall_idx >= 0) chk("stall_cycles", stall_cnt, 10);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < MAP_W*MAP_W; i++) mem[i] = '0;

        // reset values, with start held during reset
        repeat (3) @(negedge clk);
        chk("rst_addr", int'(addr_rd), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_idx", int'(out_idx), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("start_in_reset_ignored", int'(busy), 0);

        // ramp map: timing, address order, endpoint values
        for (int i = 0; i < MAP_W*MAP_W; i++) mem[i] = DW'(i);
        run_sweep(100, 1'b0, -1);
        chk("ramp_idx0", cap[0], 27);
        chk("ramp_idx168", cap[168], 675);
        chk("addr_k0", addr_log[0], 0);
        chk("addr_k1", addr_log[1], 1);
        chk("addr_k2", addr_log[2], 26);
        chk("addr_k3", addr_log[3], 27);
        chk("first_valid_cycle", first_valid, 6);
        chk("done_cycle", done_cyc, NW * 6 + 1);

        // table-driven windows
        tbl[0] = '{v0: -5,      v1: 7,      v2: 7,  v3: -100,    exp: 7};
        tbl[1] = '{v0: -3,      v1: -3,     v2: -3, v3: -3,      exp: -3};
        tbl[2] = '{v0: 0,       v1: 0,      v2: 0,  v3: 0,       exp: 0};
        tbl[3] = '{v0: -131072, v1: -1,     v2: -2, v3: -131071, exp: -1};
        tbl[4] = '{v0: 131071,  v1: -131072, v2: 5, v3: 131071,  exp: 131071};
        tbl[5] = '{v0: 1,       v1: 2,      v2: 3,  v3: 4,       exp: 4};
        tbl[6] = '{v0: 4,       v1: 3,      v2: 2,  v3: 1,       exp: 4};
        tbl[7] = '{v0: -7,      v1: -9,     v2: -8, v3: -6,      exp: -6};
        for (int i = 0; i < MAP_W*MAP_W; i++) mem[i] = '0;
        for (int t = 0; t < 8; t++)
            put_window(t * 21, tbl[t].v0, tbl[t].v1, tbl[t].v2, tbl[t].v3);
        run_sweep(100, 1'b0, -1);
        for (int t = 0; t < 8; t++)
            chk($sformatf("table_%0d", t), cap[t * 21], relu(tbl[t].exp));

        // 10-cycle backpressure on idx 4
        for (int i = 0; i < MAP_W*MAP_W; i++) mem[i] = DW'($urandom);
        run_sweep(100, 1'b0, 4);

        // reset during READ of window 50, start asserted alongside
        begin
            int seen;
            bit hit;
            seen = 0; hit = 0;
            out_ready = 1'b1;
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
            for (int cyc = 0; cyc < BUDGET; cyc++) begin
                if (out_valid && out_ready) seen++;
                if (seen == 50) begin hit = 1; break; end
                @(negedge clk);
            end
            chk("reach_window50", int'(hit), 1);
            @(negedge clk);
            chk("mid_busy_pre", int'(busy), 1);
            rst_n = 1'b0; start = 1'b1;
            @(negedge clk);
            chk("mid_rst_busy", int'(busy), 0);
            chk("mid_rst_valid", int'(out_valid), 0);
            chk("mid_rst_idx", int'(out_idx), 0);
            rst_n = 1'b1; start = 1'b0;
            @(negedge clk);
            chk("mid_rst_idle", int'(busy), 0);
        end
        run_sweep(100, 1'b0, -1);
        chk("restart_addr0", addr_log[0], 0);

        // spurious starts during READ and FIN
        run_sweep(100, 1'b1, -1);

        // random data, random backpressure
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < MAP_W*MAP_W; i++) mem[i] = DW'($urandom);
            run_sweep(60, 1'b0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
